// File: rtl/exception_trap_sequencer_pkg.sv
// exception_trap_sequencer_pkg: FSM state encoding, exception codes and sizing helper.
package exception_trap_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIRECT_IN,
    IN_TRAP,
    REDIRECT_RET,
    HALT
  } state_t;
  localparam logic [3:0] NO_E                 = 4'd0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR      = 4'd2;
  localparam logic [3:0] E_BREAKPOINT         = 4'd3;
  localparam logic [3:0] E_LOAD_MISALIGNED    = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] E_STORE_MISALIGNED   = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT = 4'd7;
  localparam logic [3:0] E_ECALL              = 4'd11;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/exception_trap_sequencer_priority_select.sv
// exc_priority_select: picks the oldest (highest-index) stage reporting a nonzero code.
module exc_priority_select
  import exception_trap_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int CODE_W     = 4,
  parameter int XLEN       = 32
) (
  input  logic [NUM_STAGES*CODE_W-1:0] code_in,
  input  logic [NUM_STAGES*XLEN-1:0]   pc_in,
  input  logic [NUM_STAGES*XLEN-1:0]   tval_in,
  output logic [idx_w(NUM_STAGES)-1:0] idx,
  output logic                         valid,
  output logic [CODE_W-1:0]            code,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              tval
);
  localparam int IW = idx_w(NUM_STAGES);
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    code  = '0;
    pc    = '0;
    tval  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (code_in[k*CODE_W +: CODE_W] != '0) begin
        idx   = IW'(k);
        valid = 1'b1;
        code  = code_in[k*CODE_W +: CODE_W];
        pc    = pc_in[k*XLEN +: XLEN];
        tval  = tval_in[k*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: rtl/exception_trap_sequencer.sv
// exception_trap_sequencer: collects per-stage exceptions and sequences trap entry/return.
// Optional EXC_TRAP_COUNT_EN enables the saturating o_trap_count counter.
module exception_trap_sequencer
  import exception_trap_sequencer_pkg::*;
#(
  parameter int              NUM_STAGES   = 2,
  parameter int              CODE_W       = 4,
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] TRAP_VEC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_STAGES*CODE_W-1:0] i_exc_code,
  input  logic [NUM_STAGES*XLEN-1:0]   i_exc_pc,
  input  logic [NUM_STAGES*XLEN-1:0]   i_exc_tval,
  input  logic                         i_mret,
  input  logic                         i_redirect_ack,
  output logic [NUM_STAGES-1:0]        o_flush,
  output logic                         o_redirect_valid,
  output logic [XLEN-1:0]              o_redirect_pc,
  output logic [CODE_W-1:0]            o_mcause,
  output logic [XLEN-1:0]              o_mepc,
  output logic [XLEN-1:0]              o_mtval,
  output logic                         o_trap_permission,
  output logic                         o_halted,
  output logic [7:0]                   o_trap_count
);
  localparam int IW = idx_w(NUM_STAGES);
  state_t                state, nxt;
  logic [3:0]            cnt;
  logic [NUM_STAGES-1:0] mask, win_mask;
  logic [IW-1:0]         win_idx;
  logic                  win_valid;
  logic [CODE_W-1:0]     win_code;
  logic [XLEN-1:0]       win_pc, win_tval;
  logic                  take;
  exc_priority_select #(.NUM_STAGES(NUM_STAGES), .CODE_W(CODE_W), .XLEN(XLEN)) u_sel (
    .code_in(i_exc_code),
    .pc_in  (i_exc_pc),
    .tval_in(i_exc_tval),
    .idx    (win_idx),
    .valid  (win_valid),
    .code   (win_code),
    .pc     (win_pc),
    .tval   (win_tval)
  );
  assign take = state == IDLE && win_valid;
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) win_mask[i] = i <= int'(win_idx);
  end
  // A nonzero code in IN_TRAP is a double fault and wins over a simultaneous mret.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         nxt = win_valid ? FLUSH : IDLE;
      FLUSH:        nxt = cnt == '0 ? REDIRECT_IN : FLUSH;
      REDIRECT_IN:  nxt = i_redirect_ack ? IN_TRAP : REDIRECT_IN;
      IN_TRAP:      nxt = win_valid ? HALT : i_mret ? REDIRECT_RET : IN_TRAP;
      REDIRECT_RET: nxt = i_redirect_ack ? IDLE : REDIRECT_RET;
      HALT:         nxt = HALT;
      default:      nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mask     <= '0;
      o_mcause <= '0;
      o_mepc   <= '0;
      o_mtval  <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        cnt      <= 4'(FLUSH_CYCLES - 1);
        mask     <= win_mask;
        o_mcause <= win_code;
        o_mepc   <= win_pc;
        o_mtval  <= win_tval;
      end else if (state == FLUSH && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  assign o_flush           = state == HALT ? '1 : state == FLUSH ? mask : '0;
  assign o_redirect_valid  = state == REDIRECT_IN || state == REDIRECT_RET;
  assign o_redirect_pc     = state == REDIRECT_IN ? TRAP_VEC : state == REDIRECT_RET ? o_mepc : '0;
  assign o_trap_permission = state == IN_TRAP || state == REDIRECT_RET;
  assign o_halted          = state == HALT;
`ifdef EXC_TRAP_COUNT_EN
  logic [7:0] traps;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) traps <= '0;
    else if (take && traps != 8'hFF) traps <= traps + 8'd1;
  end
  assign o_trap_count = traps;
`else
  assign o_trap_count = '0;
`endif
endmodule

// File: tb/tb_exception_trap_sequencer.sv
// tb_exception_trap_sequencer: table-driven cycle vectors plus reset corner sequences.
module tb_exception_trap_sequencer;
  import exception_trap_sequencer_pkg::*;
`ifdef EXC_TRAP_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_exc_code = '0;
  logic [63:0] i_exc_pc = '0;
  logic [63:0] i_exc_tval = '0;
  logic        i_mret = 1'b0;
  logic        i_redirect_ack = 1'b0;
  logic [1:0]  o_flush;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic [3:0]  o_mcause;
  logic [31:0] o_mepc;
  logic [31:0] o_mtval;
  logic        o_trap_permission;
  logic        o_halted;
  logic [7:0]  o_trap_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  exception_trap_sequencer dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_exc_code       (i_exc_code),
    .i_exc_pc         (i_exc_pc),
    .i_exc_tval       (i_exc_tval),
    .i_mret           (i_mret),
    .i_redirect_ack   (i_redirect_ack),
    .o_flush          (o_flush),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_mcause         (o_mcause),
    .o_mepc           (o_mepc),
    .o_mtval          (o_mtval),
    .o_trap_permission(o_trap_permission),
    .o_halted         (o_halted),
    .o_trap_count     (o_trap_count)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic [3:0]  c0, c1;
    logic [31:0] p0, p1, t0, t1;
    logic        mret, ack;
    logic [1:0]  flush;
    logic        rv;
    logic [31:0] rpc;
    logic [3:0]  cause;
    logic [31:0] epc, tval;
    logic        perm, halt;
  } vec_t;
  vec_t v[24];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic [1:0] f, input logic rv,
                           input logic [31:0] rpc, input logic [3:0] ca, input logic [31:0] ep,
                           input logic [31:0] tv, input logic perm, input logic halt);
    chk({tag, ".flush"}, 32'(o_flush), 32'(f));
    chk({tag, ".rv"}, 32'(o_redirect_valid), 32'(rv));
    chk({tag, ".rpc"}, o_redirect_pc, rpc);
    chk({tag, ".mcause"}, 32'(o_mcause), 32'(ca));
    chk({tag, ".mepc"}, o_mepc, ep);
    chk({tag, ".mtval"}, o_mtval, tv);
    chk({tag, ".perm"}, 32'(o_trap_permission), (perm === 1'bx) ? 32'hxxxx_xxxx : 32'(perm));
    chk({tag, ".halted"}, 32'(o_halted), 32'(halt));
  endtask
  initial begin
    v[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{0, E_LOAD_ACCESS_FAULT, 0, 32'h0008_0010, 0, 32'h4, 0, 0,
              2'b11, 0, 0, E_LOAD_ACCESS_FAULT, 32'h0008_0010, 32'h4, 0, 0};
    v[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 5, 32'h0008_0010, 32'h4, 0, 0};
    v[3]  = v[2];
    v[4]  = v[2];
    v[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 5, 32'h0008_0010, 32'h4, 1, 0};
    v[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5, 32'h0008_0010, 32'h4, 1, 0};
    v[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 32'h0008_0010, 5, 32'h0008_0010, 32'h4, 1, 0};
    v[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 5, 32'h0008_0010, 32'h4, 0, 0};
    v[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 5, 32'h0008_0010, 32'h4, 0, 0};
    v[10] = '{E_ILLEGAL_INSTR, E_ECALL, 32'h100, 32'h0008_0014, 32'h55, 32'h0008_0014, 0, 0,
              2'b11, 0, 0, E_ECALL, 32'h0008_0014, 32'h0008_0014, 0, 0};
    v[11] = '{E_INSTR_ACCESS_FAULT, 0, 32'hdead, 0, 32'hbeef, 0, 0, 0,
              2'b00, 1, 0, E_ECALL, 32'h0008_0014, 32'h0008_0014, 0, 0};
    v[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, E_ECALL, 32'h0008_0014, 32'h0008_0014, 1, 0};
    v[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 32'h0008_0014, E_ECALL, 32'h0008_0014,
              32'h0008_0014, 1, 0};
    v[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h0008_0014, E_ECALL, 32'h0008_0014,
              32'h0008_0014, 1, 0};
    v[15] = v[14];
    v[16] = v[14];
    v[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, E_ECALL, 32'h0008_0014, 32'h0008_0014, 0, 0};
    v[18] = '{E_ILLEGAL_INSTR, 0, 32'h200, 0, 32'h1234, 0, 0, 0,
              2'b01, 0, 0, E_ILLEGAL_INSTR, 32'h200, 32'h1234, 0, 0};
    v[19] = '{0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 0, E_ILLEGAL_INSTR, 32'h200, 32'h1234, 0, 0};
    v[20] = '{0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, E_ILLEGAL_INSTR, 32'h200, 32'h1234, 1, 0};
    v[21] = '{0, E_STORE_ACCESS_FAULT, 0, 32'h999, 0, 32'h888, 1, 0,
              2'b11, 0, 0, E_ILLEGAL_INSTR, 32'h200, 32'h1234, 1'bx, 1};
    v[22] = '{0, 0, 0, 0, 0, 0, 1, 1, 2'b11, 0, 0, E_ILLEGAL_INSTR, 32'h200, 32'h1234, 1'bx, 1};
    v[23] = '{E_INSTR_ACCESS_FAULT, 0, 32'h4, 0, 32'h4, 0, 0, 0,
              2'b11, 0, 0, E_ILLEGAL_INSTR, 32'h200, 32'h1234, 1'bx, 1};
    #2;
    check_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.count", 32'(o_trap_count), 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      check_out($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk);
      i_exc_code     = {v[i].c1, v[i].c0};
      i_exc_pc       = {v[i].p1, v[i].p0};
      i_exc_tval     = {v[i].t1, v[i].t0};
      i_mret         = v[i].mret;
      i_redirect_ack = v[i].ack;
      @(posedge i_clk);
      #1;
      check_out($sformatf("row%0d", i), v[i].flush, v[i].rv, v[i].rpc, v[i].cause,
                v[i].epc, v[i].tval, v[i].perm, v[i].halt);
    end
    chk("count_after_table", 32'(o_trap_count), CNT_EN ? 32'd3 : 32'd0);
    @(negedge i_clk);
    i_exc_code = '0;
    i_exc_pc = '0;
    i_exc_tval = '0;
    i_mret = 1'b0;
    i_redirect_ack = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_out("halt_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(negedge i_clk);
    i_exc_code = {E_LOAD_MISALIGNED, NO_E};
    i_exc_pc   = {32'h0008_0040, 32'h0};
    i_exc_tval = {32'h0000_0003, 32'h0};
    @(posedge i_clk);
    #1;
    check_out("mid.flush", 2'b11, 0, 0, E_LOAD_MISALIGNED, 32'h0008_0040, 32'h3, 0, 0);
    @(negedge i_clk) i_exc_code = '0;
    @(posedge i_clk);
    #1;
    check_out("mid.redir", 2'b00, 1, 0, E_LOAD_MISALIGNED, 32'h0008_0040, 32'h3, 0, 0);
    chk("mid.count", 32'(o_trap_count), 32'(CNT_EN));
    #2 i_rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("async_rst.count", 32'(o_trap_count), 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_out("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
